// File: rtl/reg_write_scheduler.sv
// reg_write_scheduler
//   Feeds a 16-bit dual-write-port register that alternates between its two
//   write ports with an internal turn toggle. Two request streams are buffered
//   in per-source FIFOs; the scheduler keeps a mirror of the register's turn
//   bit so every accepted word is written exactly once, in per-source order.
//
//   Timing: rd_busy is registered internally (rd_busy_q) before it is used.
//   The register's read_enable_1 must therefore be either driven one cycle
//   after rd_busy, or tied to that delayed copy. The decision taken in cycle t
//   is registered onto write_enable_1/2 and sampled by the register at edge t+1.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   P1    | register will accept port 1 next (primary FIFO1, skip FIFO2)
//   P2    | register will accept port 2 next (primary FIFO2, skip FIFO1)
//
// Ports
//   clk, reset (async active-low)
//   src1_valid/src1_data/src1_ready   source 1 handshake
//   src2_valid/src2_data/src2_ready   source 2 handshake
//   rd_busy                           register read in progress (see above)
//   write_enable_1/2, data_in_1/2     register write ports (registered)
//   level1/level2                     FIFO occupancy
//   idle                              both FIFOs empty, no write this cycle
module reg_write_scheduler #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src1_valid,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_ready,
  input  logic              src2_valid,
  input  logic [DATA_W-1:0] src2_data,
  output logic              src2_ready,
  input  logic              rd_busy,
  output logic              write_enable_1,
  output logic              write_enable_2,
  output logic [DATA_W-1:0] data_in_1,
  output logic [DATA_W-1:0] data_in_2,
  output logic [LW-1:0]     level1,
  output logic [LW-1:0]     level2,
  output logic              idle
);

  typedef enum logic {P1 = 1'b0, P2 = 1'b1} turn_t;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] CNT_ONE = LW'(1);
  localparam logic [LW-1:0] FULL    = LW'(DEPTH);

  logic [DATA_W-1:0] mem1_q [DEPTH];
  logic [DATA_W-1:0] mem2_q [DEPTH];
  logic [AW-1:0]     wptr1_q, rptr1_q, wptr2_q, rptr2_q;
  logic [LW-1:0]     cnt1_q, cnt2_q;

  turn_t             turn_q, turn_d;
  logic              rd_busy_q;
  logic              we1_q, we1_d, we2_q, we2_d;
  logic [DATA_W-1:0] din1_q, din1_d, din2_q, din2_d;

  logic              push1, push2, pop1, pop2;
  logic              empty1, empty2;
  logic [DATA_W-1:0] head1, head2;

  assign src1_ready = (cnt1_q < FULL);
  assign src2_ready = (cnt2_q < FULL);
  assign push1      = src1_valid && src1_ready;
  assign push2      = src2_valid && src2_ready;
  assign empty1     = (cnt1_q == '0);
  assign empty2     = (cnt2_q == '0);
  assign head1      = mem1_q[rptr1_q];
  assign head2      = mem2_q[rptr2_q];

  // A wrong-turn enable (skip) makes the register toggle without writing;
  // it is used when the primary FIFO is empty but the other one has data,
  // so the other source is not starved. The skip word is not popped.
  always_comb begin
    we1_d  = 1'b0;
    we2_d  = 1'b0;
    din1_d = din1_q;
    din2_d = din2_q;
    pop1   = 1'b0;
    pop2   = 1'b0;
    turn_d = turn_q;
    if (!rd_busy_q) begin
      if (turn_q == P1) begin
        if (!empty1) begin
          we1_d  = 1'b1;
          din1_d = head1;
          pop1   = 1'b1;
          turn_d = P2;
        end else if (!empty2) begin
          we2_d  = 1'b1;
          din2_d = head2;
          turn_d = P2;
        end
      end else begin
        if (!empty2) begin
          we2_d  = 1'b1;
          din2_d = head2;
          pop2   = 1'b1;
          turn_d = P1;
        end else if (!empty1) begin
          we1_d  = 1'b1;
          din1_d = head1;
          turn_d = P1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      turn_q    <= P1;
      rd_busy_q <= 1'b0;
      we1_q     <= 1'b0;
      we2_q     <= 1'b0;
      din1_q    <= '0;
      din2_q    <= '0;
      wptr1_q   <= '0;
      rptr1_q   <= '0;
      cnt1_q    <= '0;
      wptr2_q   <= '0;
      rptr2_q   <= '0;
      cnt2_q    <= '0;
    end else begin
      turn_q    <= turn_d;
      rd_busy_q <= rd_busy;
      we1_q     <= we1_d;
      we2_q     <= we2_d;
      din1_q    <= din1_d;
      din2_q    <= din2_d;
      if (push1) wptr1_q <= wptr1_q + PTR_ONE;
      if (pop1)  rptr1_q <= rptr1_q + PTR_ONE;
      if (push2) wptr2_q <= wptr2_q + PTR_ONE;
      if (pop2)  rptr2_q <= rptr2_q + PTR_ONE;
      if (push1 && !pop1)      cnt1_q <= cnt1_q + CNT_ONE;
      else if (!push1 && pop1) cnt1_q <= cnt1_q - CNT_ONE;
      if (push2 && !pop2)      cnt2_q <= cnt2_q + CNT_ONE;
      else if (!push2 && pop2) cnt2_q <= cnt2_q - CNT_ONE;
    end
  end

  // Storage needs no reset; occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (push1) mem1_q[wptr1_q] <= src1_data;
    if (push2) mem2_q[wptr2_q] <= src2_data;
  end

  assign write_enable_1 = we1_q;
  assign write_enable_2 = we2_q;
  assign data_in_1      = din1_q;
  assign data_in_2      = din2_q;
  assign level1         = cnt1_q;
  assign level2         = cnt2_q;
  assign idle           = empty1 && empty2 && !we1_q && !we2_q;

endmodule

// File: tb/tb_reg_write_scheduler.sv
module tb_reg_write_scheduler;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          src1_valid = 1'b0, src2_valid = 1'b0, rd_busy = 1'b0;
  logic [DW-1:0] src1_data = '0, src2_data = '0;
  logic          src1_ready, src2_ready;
  logic          write_enable_1, write_enable_2, idle;
  logic [DW-1:0] data_in_1, data_in_2;
  logic [2:0]    level1, level2;

  int n_checks = 0;
  int n_fail   = 0;

  // expected writes: {port_is_2, data}
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_got, mon_exp;

  // model of the register itself
  logic [DW-1:0] rq;
  logic          rt;

  always #5 clk = ~clk;

  reg_write_scheduler #(.DATA_W(DW), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
    .src2_valid(src2_valid), .src2_data(src2_data), .src2_ready(src2_ready),
    .rd_busy(rd_busy),
    .write_enable_1(write_enable_1), .write_enable_2(write_enable_2),
    .data_in_1(data_in_1), .data_in_2(data_in_2),
    .level1(level1), .level2(level2), .idle(idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void expect_w(input bit port2, input logic [DW-1:0] d);
    exp_q.push_back({port2, d});
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq <= '0;
      rt <= 1'b0;
    end else if (write_enable_1) begin
      if (!rt) rq <= data_in_1;
      rt <= ~rt;
    end else if (write_enable_2) begin
      if (rt) rq <= data_in_2;
      rt <= ~rt;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && (write_enable_1 || write_enable_2)) begin
      chk("enables_exclusive", 32'(write_enable_1 && write_enable_2), 32'd0);
      mon_got = write_enable_2 ? {1'b1, data_in_2} : {1'b0, data_in_1};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got port2=%0d data %h, required no write",
                 mon_got[DW], mon_got[DW-1:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("write_seq", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  // caller is between edges; returns at the negedge after the accepting edge
  task automatic push1(input logic [DW-1:0] d);
    int n = 0;
    src1_data  = d;
    src1_valid = 1'b1;
    while (!src1_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push1_timeout", 32'(src1_ready), 32'd1);
    @(negedge clk);
    src1_valid = 1'b0;
  endtask

  task automatic push2(input logic [DW-1:0] d);
    int n = 0;
    src2_data  = d;
    src2_valid = 1'b1;
    while (!src2_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push2_timeout", 32'(src2_ready), 32'd1);
    @(negedge clk);
    src2_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(exp_q.size() == 0 && idle) && n < 200);
    chk({name, "_drained"}, 32'(exp_q.size() == 0 && idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst_ready1", 32'(src1_ready), 32'd1);
    chk("rst_ready2", 32'(src2_ready), 32'd1);
    chk("rst_we", 32'({write_enable_1, write_enable_2}), 32'd0);
    chk("rst_din1", 32'(data_in_1), 32'd0);
    chk("rst_din2", 32'(data_in_2), 32'd0);
    chk("rst_levels", 32'({level1, level2}), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: single word on port 1, one-cycle latency
    expect_w(1'b0, 16'h1234);
    push1(16'h1234);
    chk("t1_we_not_yet", 32'(write_enable_1), 32'd0);
    chk("t1_level_after_push", 32'(level1), 32'd1);
    chk("t1_not_idle", 32'(idle), 32'd0);
    @(negedge clk);
    chk("t1_we1", 32'(write_enable_1), 32'd1);
    chk("t1_din1", 32'(data_in_1), 32'h1234);
    chk("t1_level_popped", 32'(level1), 32'd0);
    wait_drain("t1");
    chk("t1_reg", 32'(rq), 32'h1234);
    chk("t1_turn", 32'(rt), 32'd1);
    chk("t1_din1_held", 32'(data_in_1), 32'h1234);

    // bring turn back to P1 with a direct port-2 write
    expect_w(1'b1, 16'h0001);
    push2(16'h0001);
    wait_drain("t1b");
    chk("t1b_turn", 32'(rt), 32'd0);

    // 2: only src2 while turn=P1: skip then write
    expect_w(1'b1, 16'h5678);
    expect_w(1'b1, 16'h5678);
    push2(16'h5678);
    wait_drain("t2");
    chk("t2_reg", 32'(rq), 32'h5678);
    chk("t2_turn", 32'(rt), 32'd0);
    chk("t2_levels", 32'({level1, level2}), 32'd0);

    // 3: fill both FIFOs under rd_busy, then drain alternating
    for (int i = 1; i <= 4; i++) begin
      expect_w(1'b0, 16'h1000 + 16'(i));
      expect_w(1'b1, 16'h2000 + 16'(i));
    end
    rd_busy = 1'b1;
    fork
      begin
        for (int i = 1; i <= 4; i++) push1(16'h1000 + 16'(i));
      end
      begin
        for (int j = 1; j <= 4; j++) push2(16'h2000 + 16'(j));
      end
    join
    chk("t3_level1_full", 32'(level1), 32'd4);
    chk("t3_level2_full", 32'(level2), 32'd4);
    chk("t3_ready1_low", 32'(src1_ready), 32'd0);
    chk("t3_ready2_low", 32'(src2_ready), 32'd0);
    rd_busy = 1'b0;
    wait_drain("t3");
    chk("t3_reg", 32'(rq), 32'h2004);
    chk("t3_turn", 32'(rt), 32'd0);

    // 4: rd_busy freezes draining
    expect_w(1'b0, 16'h3001);
    expect_w(1'b1, 16'h4001);
    expect_w(1'b0, 16'h3002);
    expect_w(1'b1, 16'h4002);
    rd_busy = 1'b1;
    fork
      begin push1(16'h3001); push1(16'h3002); end
      begin push2(16'h4001); push2(16'h4002); end
    join
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_level1_frozen", 32'(level1), 32'd2);
      chk("t4_level2_frozen", 32'(level2), 32'd2);
      chk("t4_no_enable", 32'({write_enable_1, write_enable_2}), 32'd0);
    end
    chk("t4_turn_held", 32'(rt), 32'd0);
    rd_busy = 1'b0;
    wait_drain("t4");
    chk("t4_reg", 32'(rq), 32'h4002);

    // 5: FIFO1 full, 5th word stalls, then drains with skips
    expect_w(1'b0, 16'h5001);
    for (int i = 2; i <= 5; i++) begin
      expect_w(1'b0, 16'h5000 + 16'(i));
      expect_w(1'b0, 16'h5000 + 16'(i));
    end
    rd_busy = 1'b1;
    for (int i = 1; i <= 4; i++) push1(16'h5000 + 16'(i));
    src1_data  = 16'h5005;
    src1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_level1_stalled", 32'(level1), 32'd4);
      chk("t5_ready1_low", 32'(src1_ready), 32'd0);
    end
    rd_busy = 1'b0;
    push1(16'h5005);
    wait_drain("t5");
    chk("t5_reg", 32'(rq), 32'h5005);
    chk("t5_turn", 32'(rt), 32'd1);

    // 6: async reset mid-drain
    expect_w(1'b1, 16'h7001);
    rd_busy = 1'b1;
    fork
      begin push1(16'h6001); push1(16'h6002); end
      begin push2(16'h7001); push2(16'h7002); end
    join
    rd_busy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_we_dropped", 32'({write_enable_1, write_enable_2}), 32'd0);
    chk("t6_levels", 32'({level1, level2}), 32'd0);
    chk("t6_ready", 32'({src1_ready, src2_ready}), 32'd3);
    chk("t6_idle", 32'(idle), 32'd1);
    chk("t6_pending_seen", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_w(1'b0, 16'h0ABC);
    push1(16'h0ABC);
    wait_drain("t6");
    chk("t6_reg", 32'(rq), 32'h0ABC);
    chk("t6_turn", 32'(rt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
